dvi_timing_rx: RTL

Receive-side timing decoder for the 640x480 DVI Pmod video path, in the pixel-clock domain. Takes hsync/vsync/de, as the transmit path drives them onto the Pmod, and rebuilds the active-area coordinates. Measures each frame's geometry against the configured resolution and reports lock and errors. Used for loopback capture and self-check of the DDR video output.

---
 rtl/dvi_rx_pkg.sv | 15 +
 rtl/dvi_sync_edge.sv | 42 ++++
 rtl/dvi_timing_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dvi_rx_pkg.sv
// Shared types and default geometry for the DVI receive timing decoder.
// The default resolution constants are also used by the display timing generator.
package dvi_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    localparam int DEF_CORDW = 10;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

endpackage

// File: rtl/dvi_sync_edge.sv
// Input capture for one received timing signal.
// The pin is registered once and normalised so that 1 means "pulse active".
// The previous value is also registered, giving single-cycle rise/fall pulses.
// Both registers reset to the inactive level, so releasing reset never creates an edge.
module dvi_sync_edge
    import dvi_rx_pkg::*;
#(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk_pix_i,
    input  logic rst_pix_ni,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q, level_d;
    logic prev_q, prev_d;

    // Normalise polarity and shift the previous value along.
    always_comb begin
        level_d = ACTIVE_HIGH ? pin_i : ~pin_i;
        prev_d  = level_q;
    end

    // Capture and history registers, both reset inactive.
    always_ff @(posedge clk_pix_i or negedge rst_pix_ni) begin
        if (!rst_pix_ni) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            prev_q  <= prev_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/dvi_timing_rx.sv
// Receive-side timing decoder: rebuilds active-area coordinates from hsync/vsync/de,
// measures frame geometry against H_RES x V_RES and reports lock and errors.
// Optional statistics counters are built when DVI_RX_STATS_EN is defined.
module dvi_timing_rx
    import dvi_rx_pkg::*;
#(
    parameter int CORDW       = DEF_CORDW,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2,
    parameter int WDW         = 20
) (
    input  logic             clk_pix_i,
    input  logic             rst_pix_ni,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    output logic [CORDW-1:0] sx_o,
    output logic [CORDW-1:0] sy_o,
    output logic             de_o,
    output logic             line_o,
    output logic             frame_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [15:0]      frame_cnt_o,
    output logic [7:0]       err_cnt_o
);

    localparam logic [CORDW-1:0] H_LAST  = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] V_FULL  = CORDW'(V_RES);
    localparam logic [2:0]       GOOD_N  = 3'(LOCK_FRAMES);
    // One below terminal count: the timeout fires as the count reaches 2^WDW-1.
    localparam logic [WDW-1:0]   WD_LAST = {{(WDW-1){1'b1}}, 1'b0};

    logic hs_level, hs_rise, hs_fall;
    logic vs_level, vs_rise, vs_fall;
    logic de_level, de_rise, de_fall;

    dvi_sync_edge #(.ACTIVE_HIGH(SYNC_POL != 0)) u_hs (
        .clk_pix_i(clk_pix_i), .rst_pix_ni(rst_pix_ni), .pin_i(hsync_i),
        .level_o(hs_level), .rise_o(hs_rise), .fall_o(hs_fall));
    dvi_sync_edge #(.ACTIVE_HIGH(SYNC_POL != 0)) u_vs (
        .clk_pix_i(clk_pix_i), .rst_pix_ni(rst_pix_ni), .pin_i(vsync_i),
        .level_o(vs_level), .rise_o(vs_rise), .fall_o(vs_fall));
    dvi_sync_edge #(.ACTIVE_HIGH(1'b1)) u_de (
        .clk_pix_i(clk_pix_i), .rst_pix_ni(rst_pix_ni), .pin_i(de_i),
        .level_o(de_level), .rise_o(de_rise), .fall_o(de_fall));

    // hsync is captured alongside the others but no decision depends on it yet.
    logic unused_edges;
    assign unused_edges = ^{hs_level, hs_rise, hs_fall, vs_level, vs_fall};

    rx_state_t        state_q;
    logic [2:0]       good_q;
    logic             locked_q;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d, lines_q, lines_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             de_o_q, de_o_d, line_q, line_d, frame_q, frame_d, err_q, err_d;
    logic             judging, line_err, extra_err, frame_err, tmo, any_err, frame_full;

    // Geometry checks; partial frames seen in SEARCH are never judged against V_RES.
    always_comb begin
        judging    = (state_q != SEARCH);
        frame_full = (lines_q == V_FULL);
        line_err   = de_fall && (sx_q != H_LAST);
        extra_err  = judging && de_rise && frame_full;
        frame_err  = judging && vs_rise && (lines_q != '0) && !frame_full;
        tmo        = judging && !vs_rise && (wd_q == WD_LAST);
        any_err    = line_err | extra_err | frame_err | tmo;
    end

    // Coordinate counters, watchdog and next values of the output pulses.
    always_comb begin
        sx_d    = sx_q;
        sy_d    = sy_q;
        lines_d = lines_q;
        if (de_rise) begin
            sx_d = '0;
        end else if (de_level && sx_q != '1) begin
            sx_d = sx_q + 1'b1;
        end
        if (vs_rise) begin
            sy_d    = '0;
            lines_d = de_rise ? CORDW'(1) : '0;
        end else if (de_rise) begin
            sy_d    = lines_q;
            lines_d = (lines_q == '1) ? lines_q : lines_q + 1'b1;
        end
        if (!judging || vs_rise || any_err) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        de_o_d  = de_level;
        line_d  = de_rise;
        frame_d = vs_rise;
        err_d   = any_err;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_pix_i or negedge rst_pix_ni) begin
        if (!rst_pix_ni) begin
            sx_q    <= '0;
            sy_q    <= '0;
            lines_q <= '0;
            wd_q    <= '0;
            de_o_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            lines_q <= lines_d;
            wd_q    <= wd_d;
            de_o_q  <= de_o_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    // Lock state machine; an error wins over a simultaneous frame start.
    always_ff @(posedge clk_pix_i or negedge rst_pix_ni) begin
        if (!rst_pix_ni) begin
            state_q  <= SEARCH;
            good_q   <= '0;
            locked_q <= 1'b0;
        end else if (any_err) begin
            state_q  <= SEARCH;
            good_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vs_rise) begin
                        state_q <= MEASURE;
                        good_q  <= '0;
                    end
                end
                MEASURE: begin
                    if (vs_rise && frame_full) begin
                        good_q <= good_q + 3'd1;
                        if (good_q + 3'd1 == GOOD_N) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sx_o     = sx_q;
    assign sy_o     = sy_q;
    assign de_o     = de_o_q;
    assign line_o   = line_q;
    assign frame_o  = frame_q;
    assign err_o    = err_q;
    assign locked_o = locked_q;

`ifdef DVI_RX_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Frame counter wraps; error counter saturates at 255.
    always_comb begin
        frame_cnt_d = frame_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_cnt_d   = (err_q && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk_pix_i or negedge rst_pix_ni) begin
        if (!rst_pix_ni) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign err_cnt_o   = '0;
`endif

endmodule
